// File: rtl/sprite_pkg.sv
// Shared constants for the sprite reader path: sprite geometry, coordinate width,
// transparent colour key and active display size.
package sprite_pkg;

    localparam int          SPRITE_DIM              = 32;
    localparam int          SPRITE_ADDR_W           = 5;
    localparam int          COORD_W                 = 10;
    localparam int          RGB_W                   = 12;
    localparam logic [11:0] TRANSPARENT_RGB_DEFAULT = 12'hFFF;
    localparam int          H_ACTIVE                = 640;
    localparam int          V_ACTIVE                = 480;

endpackage

// File: rtl/sprite_renderer_if.sv
// Sprite position request channel: valid/ready handshake carrying the requested
// sprite top-left corner.
interface sprite_renderer_if;
    import sprite_pkg::*;

    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               pos_valid;
    logic               pos_ready;

    modport master (output pos_x, output pos_y, output pos_valid, input  pos_ready);
    modport slave  (input  pos_x, input  pos_y, input  pos_valid, output pos_ready);

endinterface

// File: rtl/sprite_hit.sv
// Combinational sprite bounds test and ROM texel address generation.
// SPRITE_SCALE2_EN selects a 64x64 footprint where each texel covers 2x2 pixels.
module sprite_hit
    import sprite_pkg::*;
(
    input  logic [COORD_W-1:0]       i_x,
    input  logic [COORD_W-1:0]       i_y,
    input  logic [COORD_W-1:0]       i_cur_x,
    input  logic [COORD_W-1:0]       i_cur_y,
    input  logic                     i_video_on,
    output logic                     o_hit,
    output logic [SPRITE_ADDR_W-1:0] o_rom_row,
    output logic [SPRITE_ADDR_W-1:0] o_rom_col
);

`ifdef SPRITE_SCALE2_EN
    localparam int BOUND = 2 * SPRITE_DIM;
`else
    localparam int BOUND = SPRITE_DIM;
`endif

    logic [COORD_W:0] w_dx;
    logic [COORD_W:0] w_dy;
    logic             w_in_x;
    logic             w_in_y;

    // One extra bit so the offset never wraps; the left/top compare rejects
    // pixels before the sprite, so there is no wrap-around at the screen edges.
    assign w_dx   = {1'b0, i_x} - {1'b0, i_cur_x};
    assign w_dy   = {1'b0, i_y} - {1'b0, i_cur_y};
    assign w_in_x = (i_x >= i_cur_x) && (w_dx < (COORD_W+1)'(BOUND));
    assign w_in_y = (i_y >= i_cur_y) && (w_dy < (COORD_W+1)'(BOUND));
    assign o_hit  = i_video_on & w_in_x & w_in_y;

`ifdef SPRITE_SCALE2_EN
    assign o_rom_row = o_hit ? w_dy[SPRITE_ADDR_W:1] : '0;
    assign o_rom_col = o_hit ? w_dx[SPRITE_ADDR_W:1] : '0;
`else
    assign o_rom_row = o_hit ? w_dy[SPRITE_ADDR_W-1:0] : '0;
    assign o_rom_col = o_hit ? w_dx[SPRITE_ADDR_W-1:0] : '0;
`endif

endmodule

// File: rtl/sprite_renderer.sv
// Sprite ROM reader: frame-gated position update, ROM addressing and a 2-cycle
// pipeline giving a pixel-aligned colour and opaque flag. Option: SPRITE_SCALE2_EN.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter logic [COORD_W-1:0] INIT_X          = 10'd304,
    parameter logic [COORD_W-1:0] INIT_Y          = 10'd224,
    parameter logic [RGB_W-1:0]   TRANSPARENT_RGB = TRANSPARENT_RGB_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [COORD_W-1:0]       x,
    input  logic [COORD_W-1:0]       y,
    input  logic                     video_on,
    input  logic                     frame_tick,
    sprite_renderer_if.slave         pos,
    output logic [SPRITE_ADDR_W-1:0] rom_row,
    output logic [SPRITE_ADDR_W-1:0] rom_col,
    input  logic [RGB_W-1:0]         color_data,
    output logic                     sprite_on,
    output logic [RGB_W-1:0]         sprite_rgb
);

    logic [COORD_W-1:0] r_cur_x;
    logic [COORD_W-1:0] r_cur_y;
    logic [COORD_W-1:0] r_pend_x;
    logic [COORD_W-1:0] r_pend_y;
    logic               r_pend_vld;
    logic               r_hit_p1;
    logic               r_sprite_on_p2;
    logic [RGB_W-1:0]   r_sprite_rgb_p2;

    logic               w_hit_p0;
    logic               w_xfer;
    logic               w_apply;
    logic               w_opaque_p1;

    assign pos.pos_ready = ~r_pend_vld;
    assign w_xfer        = pos.pos_valid & ~r_pend_vld;
    assign w_apply       = frame_tick & r_pend_vld;

    // Position control: a request parks in the pending slot and only moves into
    // the live position on a frame tick, so it can never take effect the same
    // cycle it is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_x    <= INIT_X;
            r_cur_y    <= INIT_Y;
            r_pend_vld <= 1'b0;
        end else if (w_apply) begin
            r_cur_x    <= r_pend_x;
            r_cur_y    <= r_pend_y;
            r_pend_vld <= 1'b0;
        end else if (w_xfer) begin
            r_pend_vld <= 1'b1;
        end
    end

    // Pending payload is qualified by r_pend_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_pend_x <= pos.pos_x;
            r_pend_y <= pos.pos_y;
        end
    end

    // Stage p0: bounds test and ROM address, combinational from x/y.
    sprite_hit u_hit (
        .i_x        (x),
        .i_y        (y),
        .i_cur_x    (r_cur_x),
        .i_cur_y    (r_cur_y),
        .i_video_on (video_on),
        .o_hit      (w_hit_p0),
        .o_rom_row  (rom_row),
        .o_rom_col  (rom_col)
    );

    assign w_opaque_p1 = r_hit_p1 & (color_data != TRANSPARENT_RGB);

    // Stage p1: hit flag waits alongside the ROM read; stage p2: opaque result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_p1        <= 1'b0;
            r_sprite_on_p2  <= 1'b0;
            r_sprite_rgb_p2 <= '0;
        end else begin
            r_hit_p1        <= w_hit_p0;
            r_sprite_on_p2  <= w_opaque_p1;
            r_sprite_rgb_p2 <= w_opaque_p1 ? color_data : '0;
        end
    end

    assign sprite_on  = r_sprite_on_p2;
    assign sprite_rgb = r_sprite_rgb_p2;

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Reader side of the 32x32 sprite ROMs (row/col in, 12-bit RGB out, one registered-address cycle of latency).
- Takes the current VGA pixel coordinate and the sprite's screen position, and drives the ROM row/col address.
- Absorbs the ROM latency and emits a pixel-aligned sprite colour plus an opaque/hit flag to the pixel mux.
- Sprite position updates arrive via a valid/ready handshake and take effect only at frame boundaries, so a sprite never tears mid-frame.

Parameters:
- INIT_X, 10'd304, sprite left edge after reset.
- INIT_Y, 10'd224, sprite top edge after reset.
- TRANSPARENT_RGB, 12'hFFF, ROM colour treated as background (the ROM default value).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- x  in  10  current pixel column from the sync generator.
- y  in  10  current pixel row from the sync generator.
- video_on  in  1  active-display qualifier, aligned with x/y.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- pos_x  in  10  requested sprite left edge.
- pos_y  in  10  requested sprite top edge.
- pos_valid  in  1  position request valid.
- pos_ready  out  1  position request can be accepted.
- rom_row  out  5  ROM row address (combinational).
- rom_col  out  5  ROM column address (combinational).
- color_data  in  12  ROM output, valid one cycle after address.
- sprite_on  out  1  opaque sprite pixel at the delayed coordinate.
- sprite_rgb  out  12  sprite colour; 0 when sprite_on=0.

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous, active-low.
- Reset values:
  - cur_x=INIT_X, cur_y=INIT_Y; pending empty; pos_ready=1.
  - sprite_on=0, sprite_rgb=0.
  - hit pipeline flags cleared.
- Hit test (cycle N, combinational):
  - dx = x - cur_x and dy = y - cur_y, computed 11-bit unsigned with x/y zero-extended.
  - hit = video_on & x>=cur_x & dx<32 & y>=cur_y & dy<32.
  - No wrap: a sprite near col 639 or row 479 simply clips.
- Address drive:
  - rom_row = dy[4:0], rom_col = dx[4:0] when hit; both 0 otherwise.
  - The ROM captures the address at the end of cycle N.
- Pipeline:
  - hit_d1 is registered at the end of N; color_data is valid during N+1.
  - At the end of N+1: sprite_on <= hit_d1 & (color_data != TRANSPARENT_RGB); sprite_rgb <= that ? color_data : 0.
  - Fixed latency of 2 clocks from x/y to sprite_on/sprite_rgb. The downstream mux delays its own x/y-based signals by 2.
- Position handshake:
  - pos_ready = ~pending_valid.
  - Transfer occurs when pos_valid & pos_ready; pos_x/pos_y are stored into the pending register.
  - On frame_tick with pending_valid: cur_x/cur_y <= pending, pending_valid <= 0, so pos_ready rises the next cycle.
  - frame_tick with no pending: cur_x/cur_y hold.
  - Transfer and frame_tick in the same cycle with pending empty: the new value stays pending and applies at the next frame_tick. There is never a same-cycle bypass.
  - pos_valid while pos_ready=0: ignored; the requester holds its request.
- Mid-frame: cur_x/cur_y never change outside frame_tick.
- Reset mid-operation: asynchronous clear to the reset values above. Any pending request is discarded.

Optional Feature:
- SPRITE_SCALE2_EN defined:
  - Sprite is drawn 64x64; the bound becomes dx<64, dy<64.
  - rom_row = dy[5:1], rom_col = dx[5:1], so each ROM texel covers 2x2 pixels.
  - Latency unchanged.
- Undefined: native 32x32 as described above.

Decomposition:
- sprite_pkg holds:
  - SPRITE_DIM=32 and SPRITE_ADDR_W=5.
  - COORD_W=10.
  - TRANSPARENT_RGB_DEFAULT=12'hFFF.
  - H_ACTIVE=640, V_ACTIVE=480.
- Sub-module sprite_hit is natural: combinational bounds compare and offset generation (x, y, cur_x, cur_y, video_on -> hit, rom_row, rom_col). It is reusable by every sprite instance.
- sprite_renderer keeps the position handshake, the pending register and the output pipeline.

Test Plan:
- Reset release, no requests: cur=(304,224). x=304,y=224,video_on=1 gives rom_row=0, rom_col=0; sprite_on/sprite_rgb follow the ROM word 2 cycles later. x=303 gives rom_row=rom_col=0 and sprite_on=0 two cycles later.
- Transparency: ROM returns 12'hFFF at an in-bounds pixel -> sprite_on=0, sprite_rgb=0. ROM returns 12'h000 -> sprite_on=1, sprite_rgb=12'h000.
- Handshake and frame gating:
  - pos_valid with (100,50) mid-frame -> pos_ready=0 the next cycle, and old position still rendered.
  - After frame_tick -> x=100,y=50 hits with rom_row=rom_col=0, and pos_ready=1.
- Request collisions:
  - Second pos_valid (200,60) while pending is ignored. After frame_tick the first request (100,50) is applied.
  - Transfer coinciding with frame_tick applies only at the following frame_tick.
- Edge clipping: cur=(620,470), x=639,y=479 -> hit, rom_col=19, rom_row=9. x=0 never hits (no wrap). video_on=0 in bounds -> sprite_on=0.
- Async reset asserted mid-line with a request pending -> outputs 0 immediately, pending dropped, pos_ready=1, cur=(304,224). With SPRITE_SCALE2_EN: x=cur_x+63 -> rom_col=31; x=cur_x+64 -> no hit.
